// File: rtl/mem_stage_lsu.sv
// Memory stage load/store unit: issues one word-aligned data-memory access per
// instruction, waits for ack, and registers the writeback fields.
module mem_stage_lsu #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned WB_MUX_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic [31:0]           alu_out,
  input  logic [31:0]           store_data,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  reg_write,
  input  logic [WB_MUX_W-1:0]   wb_mux,
  input  logic [2:0]            funct3,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [31:0]           dmem_addr,
  output logic [31:0]           dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_ack,
  output logic [31:0]           alu_out_wb,
  output logic [31:0]           load_data_wb,
  output logic [REG_ADDR_W-1:0] rd_addr_out,
  output logic                  reg_write_out,
  output logic [WB_MUX_W-1:0]   wb_mux_out,
  output logic [2:0]            funct3_out,
  output logic                  out_valid,
  output logic                  mem_fault
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic                  kill_q, kill_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [DATA_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     p_alu_q, p_alu_d;
  logic [REG_ADDR_W-1:0] p_rd_q, p_rd_d;
  logic                  p_rw_q, p_rw_d;
  logic [WB_MUX_W-1:0]   p_wbm_q, p_wbm_d;
  logic [2:0]            p_f3_q, p_f3_d;
  logic                  p_load_q, p_load_d;
  logic [DATA_W-1:0]     alu_wb_q, alu_wb_d;
  logic [DATA_W-1:0]     ld_wb_q, ld_wb_d;
  logic [REG_ADDR_W-1:0] rd_out_q, rd_out_d;
  logic [WB_MUX_W-1:0]   wbm_out_q, wbm_out_d;
  logic [2:0]            f3_out_q, f3_out_d;
  logic                  valid_q, valid_d;
  logic                  rw_out_q, rw_out_d;
  logic                  fault_q, fault_d;

  logic              accept_c;
  logic              is_mem_c;
  logic              fault_c;
  logic              kill_now_c;
  logic [BE_W-1:0]   st_be_c;
  logic [DATA_W-1:0] st_wdata_c;
  logic [DATA_W-1:0] ld_shift_c;
  logic [DATA_W-1:0] ld_ext_c;

  assign in_ready   = (state_q == S_IDLE);
  assign accept_c   = in_valid & in_ready & ~flush;
  assign is_mem_c   = mem_read | mem_write;
  assign kill_now_c = kill_q | flush;

  // Illegal accesses are resolved at acceptance and never reach memory.
  always_comb begin
    fault_c = 1'b0;
    if (funct3[1:0] == 2'b01 && alu_out[0])                fault_c = 1'b1;
    if (funct3[1:0] == 2'b10 && alu_out[1:0] != 2'b00)     fault_c = 1'b1;
    if (mem_read && (funct3 == 3'b011 || funct3[2:1] == 2'b11)) fault_c = 1'b1;
    if (mem_write && funct3 > 3'b010)                       fault_c = 1'b1;
    if (mem_read && mem_write)                              fault_c = 1'b1;
    fault_c = fault_c & is_mem_c;
  end

  // Store lanes: narrow data replicated so any enabled lane carries it.
  always_comb begin
    st_be_c    = 4'b1111;
    st_wdata_c = store_data;
    case (funct3[1:0])
      2'b00: begin
        st_be_c    = 4'b0001 << alu_out[1:0];
        st_wdata_c = {4{store_data[7:0]}};
      end
      2'b01: begin
        st_be_c    = 4'b0011 << {alu_out[1], 1'b0};
        st_wdata_c = {2{store_data[15:0]}};
      end
      default: begin
        st_be_c    = 4'b1111;
        st_wdata_c = store_data;
      end
    endcase
  end

  // Load extraction from the returned word using the captured byte offset.
  always_comb begin
    ld_shift_c = dmem_rdata >> {p_alu_q[1:0], 3'b000};
    case (p_f3_q)
      3'b000:  ld_ext_c = {{24{ld_shift_c[7]}}, ld_shift_c[7:0]};
      3'b001:  ld_ext_c = {{16{ld_shift_c[15]}}, ld_shift_c[15:0]};
      3'b100:  ld_ext_c = {24'd0, ld_shift_c[7:0]};
      3'b101:  ld_ext_c = {16'd0, ld_shift_c[15:0]};
      default: ld_ext_c = dmem_rdata;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    req_d     = req_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    p_alu_d   = p_alu_q;
    p_rd_d    = p_rd_q;
    p_rw_d    = p_rw_q;
    p_wbm_d   = p_wbm_q;
    p_f3_d    = p_f3_q;
    p_load_d  = p_load_q;
    alu_wb_d  = alu_wb_q;
    ld_wb_d   = ld_wb_q;
    rd_out_d  = rd_out_q;
    wbm_out_d = wbm_out_q;
    f3_out_d  = f3_out_q;
    valid_d   = 1'b0;
    rw_out_d  = 1'b0;
    fault_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (!is_mem_c || fault_c) begin
            alu_wb_d  = alu_out;
            ld_wb_d   = '0;
            rd_out_d  = rd_addr;
            wbm_out_d = wb_mux;
            f3_out_d  = funct3;
            valid_d   = 1'b1;
            fault_d   = fault_c;
            rw_out_d  = reg_write & ~fault_c;
          end else begin
            state_d  = S_WAIT;
            kill_d   = 1'b0;
            req_d    = 1'b1;
            we_d     = mem_write;
            be_d     = mem_write ? st_be_c : 4'b1111;
            addr_d   = {alu_out[31:2], 2'b00};
            wdata_d  = mem_write ? st_wdata_c : '0;
            p_alu_d  = alu_out;
            p_rd_d   = rd_addr;
            p_rw_d   = reg_write;
            p_wbm_d  = wb_mux;
            p_f3_d   = funct3;
            p_load_d = mem_read;
          end
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          state_d   = S_IDLE;
          req_d     = 1'b0;
          kill_d    = 1'b0;
          alu_wb_d  = p_alu_q;
          ld_wb_d   = p_load_q ? ld_ext_c : '0;
          rd_out_d  = p_rd_q;
          wbm_out_d = p_wbm_q;
          f3_out_d  = p_f3_q;
          valid_d   = ~kill_now_c;
          rw_out_d  = p_rw_q & ~kill_now_c;
        end else if (flush) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      kill_q    <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      p_alu_q   <= '0;
      p_rd_q    <= '0;
      p_rw_q    <= 1'b0;
      p_wbm_q   <= '0;
      p_f3_q    <= '0;
      p_load_q  <= 1'b0;
      alu_wb_q  <= '0;
      ld_wb_q   <= '0;
      rd_out_q  <= '0;
      wbm_out_q <= '0;
      f3_out_q  <= '0;
      valid_q   <= 1'b0;
      rw_out_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      kill_q    <= kill_d;
      req_q     <= req_d;
      we_q      <= we_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      p_alu_q   <= p_alu_d;
      p_rd_q    <= p_rd_d;
      p_rw_q    <= p_rw_d;
      p_wbm_q   <= p_wbm_d;
      p_f3_q    <= p_f3_d;
      p_load_q  <= p_load_d;
      alu_wb_q  <= alu_wb_d;
      ld_wb_q   <= ld_wb_d;
      rd_out_q  <= rd_out_d;
      wbm_out_q <= wbm_out_d;
      f3_out_q  <= f3_out_d;
      valid_q   <= valid_d;
      rw_out_q  <= rw_out_d;
      fault_q   <= fault_d;
    end
  end

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_be       = be_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign alu_out_wb    = alu_wb_q;
  assign load_data_wb  = ld_wb_q;
  assign rd_addr_out   = rd_out_q;
  assign wb_mux_out    = wbm_out_q;
  assign funct3_out    = f3_out_q;
  assign out_valid     = valid_q;
  assign reg_write_out = rw_out_q;
  assign mem_fault     = fault_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed scenarios plus random instructions checked
// against a transaction-level model of the load/store rules.
module tb_mem_stage_lsu;

  localparam int unsigned RW = 5;
  localparam int unsigned WW = 2;

  logic          clk, rst_n, in_valid, in_ready, flush;
  logic [31:0]   alu_out, store_data;
  logic [RW-1:0] rd_addr, rd_addr_out;
  logic          reg_write, reg_write_out;
  logic [WW-1:0] wb_mux, wb_mux_out;
  logic [2:0]    funct3, funct3_out;
  logic          mem_read, mem_write;
  logic          dmem_req, dmem_we, dmem_ack;
  logic [31:0]   dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]    dmem_be;
  logic [31:0]   alu_out_wb, load_data_wb;
  logic          out_valid, mem_fault;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage_lsu #(.REG_ADDR_W(RW), .WB_MUX_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .alu_out(alu_out), .store_data(store_data), .rd_addr(rd_addr), .reg_write(reg_write),
    .wb_mux(wb_mux), .funct3(funct3), .mem_read(mem_read), .mem_write(mem_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .alu_out_wb(alu_out_wb), .load_data_wb(load_data_wb), .rd_addr_out(rd_addr_out),
    .reg_write_out(reg_write_out), .wb_mux_out(wb_mux_out), .funct3_out(funct3_out),
    .out_valid(out_valid), .mem_fault(mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Access size in bytes from funct3: 1, 2 or 4.
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << int'(f3[1:0]);
  endfunction

  function automatic bit ref_fault(input bit mr, input bit mw, input logic [2:0] f3,
                                   input logic [31:0] addr);
    int f;
    f = int'(f3);
    if (!mr && !mw) return 1'b0;
    if (mr && mw) return 1'b1;
    if (mr && !(f == 0 || f == 1 || f == 2 || f == 4 || f == 5)) return 1'b1;
    if (mw && f > 2) return 1'b1;
    return (int'(addr[1:0]) % nbytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input bit mw, input logic [2:0] f3,
                                        input logic [31:0] addr);
    int m;
    if (!mw) return 4'hF;
    m = ((1 << nbytes(f3)) - 1) << int'(addr[1:0]);
    return 4'(m);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
    if (nbytes(f3) == 1) return {24'd0, sd[7:0]} * 32'h01010101;
    if (nbytes(f3) == 2) return {16'd0, sd[15:0]} * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int nb;
    logic [31:0] v, mask;
    nb = 8 * nbytes(f3);
    if (nb >= 32) return rdata;
    v    = rdata >> (8 * int'(addr[1:0]));
    mask = (32'd1 << nb) - 32'd1;
    v    = v & mask;
    if (!f3[2] && v[nb-1]) v = v | ~mask;
    return v;
  endfunction

  // One instruction end to end; flush_at is the wait-cycle index carrying flush (-1 none).
  task automatic run_op(input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] rdata,
                        input logic [RW-1:0] rd, input bit rw, input logic [WW-1:0] wbm,
                        input logic [2:0] f3, input bit mr, input bit mw,
                        input int ack_dly, input int flush_at);
    bit flt, killed, held_ok;
    flt = ref_fault(mr, mw, f3, alu);
    held_ok = 1'b1;
    chk("in_ready_pre", 32'(in_ready), 32'd1);
    in_valid = 1'b1; alu_out = alu; store_data = sd; rd_addr = rd; reg_write = rw;
    wb_mux = wbm; funct3 = f3; mem_read = mr; mem_write = mw;
    cyc();
    in_valid = 1'b0; alu_out = $urandom; store_data = $urandom; rd_addr = RW'($urandom);
    funct3 = 3'($urandom); reg_write = 1'($urandom);
    if ((!mr && !mw) || flt) begin
      chk("imm_valid", 32'(out_valid), 32'd1);
      chk("imm_fault", 32'(mem_fault), 32'(flt));
      chk("imm_rw", 32'(reg_write_out), 32'(rw && !flt));
      chk("imm_alu", alu_out_wb, alu);
      chk("imm_rd", 32'(rd_addr_out), 32'(rd));
      chk("imm_wbm", 32'(wb_mux_out), 32'(wbm));
      chk("imm_f3", 32'(funct3_out), 32'(f3));
      chk("imm_noreq", 32'(dmem_req), 32'd0);
      if (!mr) chk("imm_ld0", load_data_wb, 32'd0);
    end else begin
      chk("acc_req", 32'(dmem_req), 32'd1);
      chk("acc_addr", dmem_addr, alu & 32'hFFFF_FFFC);
      chk("acc_we", 32'(dmem_we), 32'(mw));
      chk("acc_be", 32'(dmem_be), 32'(ref_be(mw, f3, alu)));
      if (mw) chk("acc_wdata", dmem_wdata, ref_wdata(f3, sd));
      chk("acc_ready", 32'(in_ready), 32'd0);
      chk("acc_novalid", 32'(out_valid), 32'd0);
      killed = 1'b0;
      for (int w = 0; w <= ack_dly; w++) begin
        dmem_ack = (w == ack_dly);
        dmem_rdata = dmem_ack ? rdata : $urandom;
        flush = (w == flush_at);
        if (flush) killed = 1'b1;
        in_valid = 1'($urandom);
        cyc();
        dmem_ack = 1'b0; flush = 1'b0; in_valid = 1'b0;
        if (w < ack_dly) begin
          chk("wait_req", 32'(dmem_req), 32'd1);
          chk("wait_addr", dmem_addr, alu & 32'hFFFF_FFFC);
          chk("wait_ready", 32'(in_ready), 32'd0);
          chk("wait_novalid", 32'(out_valid), 32'd0);
        end else begin
          chk("done_req", 32'(dmem_req), 32'd0);
          chk("done_ready", 32'(in_ready), 32'd1);
          chk("done_valid", 32'(out_valid), 32'(!killed));
          chk("done_rw", 32'(reg_write_out), 32'(rw && !killed));
          chk("done_fault", 32'(mem_fault), 32'd0);
          if (!killed) begin
            chk("done_alu", alu_out_wb, alu);
            chk("done_rd", 32'(rd_addr_out), 32'(rd));
            chk("done_ld", load_data_wb, mr ? ref_load(f3, alu, rdata) : 32'd0);
          end
        end
      end
      held_ok = !killed;
    end
    cyc();
    chk("held_valid", 32'(out_valid), 32'd0);
    chk("held_rw", 32'(reg_write_out), 32'd0);
    chk("held_fault", 32'(mem_fault), 32'd0);
    chk("held_req", 32'(dmem_req), 32'd0);
    if (held_ok) chk("held_alu", alu_out_wb, alu);
  endtask

  initial begin
    int kind, adly, fat;
    logic [2:0] rf3;
    logic [31:0] ra;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; alu_out = '0; store_data = '0;
    rd_addr = '0; reg_write = 1'b0; wb_mux = '0; funct3 = '0; mem_read = 1'b0;
    mem_write = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    #12;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_rw", 32'(reg_write_out), 32'd0);
    chk("rst_fault", 32'(mem_fault), 32'd0);
    chk("rst_alu", alu_out_wb, 32'd0);
    chk("rst_ld", load_data_wb, 32'd0);
    chk("rst_rd", 32'(rd_addr_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // ALU op, LB, SH with delayed ack, misaligned LW, flushed LW then ALU op.
    run_op(32'h1234_5678, 32'd0, 32'd0, RW'(5), 1'b1, WW'(1), 3'b000, 1'b0, 1'b0, 0, -1);
    run_op(32'h0000_1003, 32'd0, 32'h80FF_0000, RW'(7), 1'b1, WW'(2), 3'b000, 1'b1, 1'b0, 0, -1);
    chk("lb_value", load_data_wb, 32'hFFFF_FF80);
    run_op(32'h0000_2002, 32'h0000_ABCD, 32'd0, RW'(0), 1'b0, WW'(0), 3'b001, 1'b0, 1'b1, 3, -1);
    run_op(32'h0000_3001, 32'd0, 32'd0, RW'(9), 1'b1, WW'(2), 3'b010, 1'b1, 1'b0, 0, -1);
    run_op(32'h0000_4000, 32'd0, 32'hDEAD_BEEF, RW'(3), 1'b1, WW'(2), 3'b010, 1'b1, 1'b0, 2, 0);
    run_op(32'h0BAD_F00D, 32'd0, 32'd0, RW'(4), 1'b1, WW'(0), 3'b111, 1'b0, 1'b0, 0, -1);

    // Flush while idle drops the instruction.
    in_valid = 1'b1; flush = 1'b1; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b1;
    cyc();
    in_valid = 1'b0; flush = 1'b0;
    chk("fl_idle_valid", 32'(out_valid), 32'd0);
    chk("fl_idle_ready", 32'(in_ready), 32'd1);
    chk("fl_idle_req", 32'(dmem_req), 32'd0);

    // Stray ack while idle.
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    cyc();
    dmem_ack = 1'b0;
    chk("ack_idle_valid", 32'(out_valid), 32'd0);
    chk("ack_idle_req", 32'(dmem_req), 32'd0);
    chk("ack_idle_ready", 32'(in_ready), 32'd1);

    // Reset during WAIT abandons the access; a later ack does nothing.
    in_valid = 1'b1; alu_out = 32'h0000_5000; funct3 = 3'b010; mem_read = 1'b1;
    mem_write = 1'b0; reg_write = 1'b1; rd_addr = RW'(6);
    cyc();
    in_valid = 1'b0;
    chk("rw_req", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_req_drop", 32'(dmem_req), 32'd0);
    chk("rw_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'h1357_9BDF;
    cyc();
    dmem_ack = 1'b0;
    chk("rw_ack_valid", 32'(out_valid), 32'd0);
    chk("rw_ack_req", 32'(dmem_req), 32'd0);
    chk("rw_ack_ready", 32'(in_ready), 32'd1);
    chk("rw_ack_ld", load_data_wb, 32'd0);
    chk("rw_ack_rw", 32'(reg_write_out), 32'd0);

    // Random instruction mix.
    for (int i = 0; i < 80; i++) begin
      kind = int'($urandom_range(0, 7));
      rf3  = 3'($urandom);
      ra   = $urandom;
      if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
      adly = int'($urandom_range(0, 3));
      fat  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      if (fat > adly) fat = -1;
      run_op(ra, $urandom, $urandom, RW'($urandom), 1'($urandom), WW'($urandom), rf3,
             kind >= 2 && kind <= 4 || kind == 7, kind >= 5, adly, fat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, destination register address width.
REQ-002 SHALL have parameter WB_MUX_W, default 2, writeback-select width.
REQ-003 SHALL have a fixed data width of 32 bits; this width is not a parameter.
REQ-004 SHALL run on one clock with asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  upstream instruction valid.
REQ-007 in_ready  out  1  stage can accept; low while a memory access is outstanding.
REQ-008 flush  in  1  kill the current and the in-flight instruction.
REQ-009 alu_out  in  32  result / effective address.
REQ-010 store_data  in  32  rs2 value for stores.
REQ-011 rd_addr  in  REG_ADDR_W; reg_write  in  1; wb_mux  in  WB_MUX_W; funct3  in  3: control fields.
REQ-012 mem_read  in  1; mem_write  in  1: access type.
REQ-013 dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32 (word-aligned); dmem_wdata  out  32; dmem_be  out  4.
REQ-014 dmem_rdata  in  32; dmem_ack  in  1: memory response.
REQ-015 alu_out_wb  out  32; load_data_wb  out  32; rd_addr_out  out  REG_ADDR_W; reg_write_out  out  1; wb_mux_out  out  WB_MUX_W; funct3_out  out  3: registered writeback fields.
REQ-016 out_valid  out  1; mem_fault  out  1: registered writeback valid and access fault.

Function
REQ-017 SHALL implement FSM states IDLE and WAIT; in_ready = (state==IDLE).
REQ-018 Accept condition: in_valid & in_ready & ~flush.
REQ-019 Non-memory op (mem_read=mem_write=0) accepted: next edge loads all writeback fields, out_valid=1; latency 1 cycle.
REQ-020 Fault, decided at acceptance: misaligned halfword (addr[0]=1), misaligned word (addr[1:0]!=0), or load funct3 in {011,110,111}.
REQ-021 Fault, decided at acceptance (continued): store funct3 not in {000,001,010}, or mem_read & mem_write both high.
REQ-022 Faulting op: no dmem_req; next edge out_valid=1, mem_fault=1, reg_write_out=0.
REQ-023 Valid memory op accepted: next edge state->WAIT and dmem_req=1.
REQ-024 Valid memory op accepted (continued): dmem_addr={alu_out[31:2],2'b00} and dmem_we=mem_write are registered and held stable until ack.
REQ-025 Store byte enables: SB be=0001<<addr[1:0]; SH be=0011<<{addr[1],1'b0}; SW be=1111.
REQ-026 Store write data: wdata replicates the byte/halfword across all lanes.
REQ-027 Load byte enables: be=1111.
REQ-028 In WAIT, dmem_ack sampled high: next edge dmem_req=0, state->IDLE, writeback fields loaded, out_valid=1; minimum memory-op latency 2 cycles.
REQ-029 Load extraction from dmem_rdata by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW direct; registered into load_data_wb.
REQ-030 load_data_wb SHALL be 0 for stores and non-memory ops.
REQ-031 dmem_ack while IDLE SHALL be ignored.
REQ-032 Held state (out_valid, reg_write_out, mem_fault): each is 0 on any edge without a completion; other writeback fields hold their last values.
REQ-033 flush in IDLE: incoming instruction dropped, out_valid=0 next edge.
REQ-034 flush in WAIT: sets kill flag; the access is not aborted (the store still writes); on ack, out_valid=0, reg_write_out=0, mem_fault=0; kill clears.
REQ-035 flush simultaneous with ack in WAIT SHALL kill that completion.
REQ-036 reg_write_out SHALL equal reg_write & completion & ~mem_fault & ~kill.

Reset
REQ-037 rst_n low asynchronously: state=IDLE, kill=0, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0.
REQ-038 rst_n low asynchronously (continued): out_valid=0, reg_write_out=0, mem_fault=0, all writeback fields 0.
REQ-039 Reset mid-WAIT SHALL abandon the access (dmem_req drops immediately); a later stray ack is ignored.

Verification
REQ-040 ALU op alu_out=0x12345678, rd=5, reg_write=1 -> next cycle out_valid=1, alu_out_wb=0x12345678, rd_addr_out=5, reg_write_out=1.
REQ-041 LB addr=0x1003, rdata=0x80FF_0000, ack on 1st WAIT cycle -> dmem_addr=0x1000, be=1111, load_data_wb=0xFFFFFF80, out_valid 2 cycles after accept.
REQ-042 SH addr=0x2002, store_data=0x0000ABCD, ack after 3 wait cycles -> be=1100, wdata=0xABCDABCD, in_ready=0 for 4 cycles.
REQ-043 LW addr=0x3001 -> no dmem_req, out_valid=1, mem_fault=1, reg_write_out=0.
REQ-044 flush asserted in WAIT of LW -> dmem_req held until ack, then out_valid=0, reg_write_out=0; next op accepted normally.
REQ-045 rst_n pulsed low during WAIT -> dmem_req=0 immediately, in_ready=1; ack asserted after release -> no output change.
